ram_burst_master: RTL and testbench

Burst initiator for one port of the team's synchronous RAM (WIDTH x DEPTH, write when we=1, registered read data one edge after address when we=0). It accepts write/read burst commands over valid/ready handshakes and drives `ram_addr`/`ram_din`/`ram_we` with auto-incrementing, wrapping addresses. Read data returns in order on a valid/ready stream. It sits between a client (DMA, test sequencer) and a single RAM port.

---
 rtl/ram_master_pkg.sv | 17 +
 rtl/ram_rd_return.sv | 57 +++++
 rtl/ram_burst_master.sv | 133 +++++++++++++
 tb/tb_ram_burst_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_master_pkg.sv
// Shared definitions for the RAM burst master: controller state encodings
// and the wrapping address increment.
package ram_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    // depth must be a power of two, so masking with depth-1 gives the wrap
    function automatic int unsigned wrap_inc(input int unsigned addr,
                                             input int unsigned depth);
        return (addr + 32'd1) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/ram_rd_return.sv
// Read return path: tracks the single outstanding RAM read and holds the
// returned beat on the rd_* stream until the client accepts it.
module ram_rd_return #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_req_i,
    input  logic             issue_last_i,
    input  logic [WIDTH-1:0] ram_dout_i,
    input  logic             rd_ready_i,
    output logic             issue_ok_o,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_last_o
);

    logic             pending_q;
    logic             pending_last_q;
    logic             rd_valid_q;
    logic             rd_last_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             issue_fire;

    // A new read may go out only when nothing is in flight and the output
    // register is empty or being emptied this cycle, so no beat is lost.
    assign issue_ok_o = !pending_q && (!rd_valid_q || rd_ready_i);
    assign issue_fire = issue_req_i && issue_ok_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q      <= 1'b0;
            pending_last_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            pending_q <= issue_fire;
            if (issue_fire) begin
                pending_last_q <= issue_last_i;
            end
            if (pending_q) begin
                rd_data_q  <= ram_dout_i;
                rd_valid_q <= 1'b1;
                rd_last_q  <= pending_last_q;
            end else if (rd_valid_q && rd_ready_i) begin
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_last_o  = rd_last_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for one synchronous RAM port: accepts write/read burst
// commands and drives the RAM with wrapping auto-incrementing addresses.
module ram_burst_master
    import ram_master_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned DEPTH    = 64,
    parameter int          ADDR_BUS = $clog2(DEPTH),
    parameter int          LEN_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_BUS-1:0] cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [WIDTH-1:0]    wr_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_last,
    output logic [ADDR_BUS-1:0] ram_addr,
    output logic [WIDTH-1:0]    ram_din,
    output logic                ram_we,
    input  logic [WIDTH-1:0]    ram_dout,
    output logic                busy
);

    localparam int CNT_W = LEN_W + 1;

    state_e              state_q, state_d;
    logic [ADDR_BUS-1:0] cur_addr_q, cur_addr_d, next_addr;
    logic [CNT_W-1:0]    beats_q, beats_d, count_q, count_d;
    logic                issue_req, issue_ok, last_beat;
    logic                ret_valid, ret_last;

    assign next_addr = ADDR_BUS'(wrap_inc(32'(cur_addr_q), 32'(DEPTH)));

    // count_q counts write handshakes or read issues within the burst
    assign last_beat = (count_q == beats_q - CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        beats_d    = beats_q;
        count_d    = count_q;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
        issue_req  = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    cmd_ready = 1'b1;
                    ram_addr  = cur_addr_q;
                    if (cmd_valid) begin
                        cur_addr_d = cmd_addr;
                        beats_d    = CNT_W'(cmd_len) + CNT_W'(1);
                        count_d    = '0;
                        state_d    = cmd_we ? WRITE : READ;
                    end
                end
                WRITE: begin
                    wr_ready = 1'b1;
                    ram_we   = wr_valid;
                    ram_addr = cur_addr_q;
                    ram_din  = wr_data;
                    if (wr_valid) begin
                        cur_addr_d = next_addr;
                        count_d    = count_q + CNT_W'(1);
                        if (last_beat) begin
                            state_d = IDLE;
                        end
                    end
                end
                READ: begin
                    ram_addr  = cur_addr_q;
                    issue_req = (count_q < beats_q);
                    if (issue_req && issue_ok) begin
                        cur_addr_d = next_addr;
                        count_d    = count_q + CNT_W'(1);
                    end
                    if (ret_valid && rd_ready && ret_last) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            beats_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            beats_q    <= beats_d;
            count_q    <= count_d;
        end
    end

    ram_rd_return #(
        .WIDTH(WIDTH)
    ) u_rd_return (
        .clk         (clk),
        .rst         (rst),
        .issue_req_i (issue_req),
        .issue_last_i(last_beat),
        .ram_dout_i  (ram_dout),
        .rd_ready_i  (rd_ready),
        .issue_ok_o  (issue_ok),
        .rd_valid_o  (ret_valid),
        .rd_data_o   (rd_data),
        .rd_last_o   (ret_last)
    );

    // Status outputs are forced quiet for the whole time reset is held low
    assign rd_valid = ret_valid && rst;
    assign rd_last  = ret_last && rst;
    assign busy     = (state_q != IDLE) && rst;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed testbench for ram_burst_master with a behavioural synchronous RAM
// attached to its RAM port.
module tb_ram_burst_master;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 64;
    localparam int ADDR_BUS = 6;
    localparam int LEN_W    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                cmd_valid, cmd_ready, cmd_we;
    logic [ADDR_BUS-1:0] cmd_addr;
    logic [LEN_W-1:0]    cmd_len;
    logic                wr_valid, wr_ready;
    logic [WIDTH-1:0]    wr_data;
    logic                rd_valid, rd_ready, rd_last;
    logic [WIDTH-1:0]    rd_data;
    logic [ADDR_BUS-1:0] ram_addr;
    logic [WIDTH-1:0]    ram_din, ram_dout;
    logic                ram_we, busy;

    logic [WIDTH-1:0]    mem [DEPTH];
    bit                  memLoaded;
    int                  compared   = 0;
    int                  mismatched = 0;

    ram_burst_master #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BUS(ADDR_BUS), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: preloaded with 0x80+addr, registered read data
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h80 + 8'(i);
            memLoaded <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end else begin
            ram_dout <= mem[ram_addr];
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic cv, input logic cw, input logic [5:0] ca,
                                 input logic [3:0] cl, input logic wv,
                                 input logic [7:0] wd, input logic rr);
        cmd_valid = cv;
        cmd_we    = cw;
        cmd_addr  = ca;
        cmd_len   = cl;
        wr_valid  = wv;
        wr_data   = wd;
        rd_ready  = rr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] wdat  [4];
        logic [5:0] waddr [4];
        logic [6:0] wvPat;
        int         beats;
        int         k;
        logic       rr;
        logic       expValid;

        wdat  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        waddr = '{6'h3E, 6'h3F, 6'h00, 6'h01};
        wvPat = 7'b1011001;

        // Reset held with a command offered: nothing may be accepted
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 6'h3E, 4'd3, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            #1;
            checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h0);
            checkOutput("rst_wr_ready",  32'(wr_ready),  32'h0);
            checkOutput("rst_ram_we",    32'(ram_we),    32'h0);
            checkOutput("rst_rd_valid",  32'(rd_valid),  32'h0);
            checkOutput("rst_busy",      32'(busy),      32'h0);
            checkOutput("rst_ram_addr",  32'(ram_addr),  32'h0);
            checkOutput("rst_ram_din",   32'(ram_din),   32'h0);
        end
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 6'h00, 4'd0, 1'b0, 8'h00, 1'b0);
        nextCycle();
        #1;
        checkOutput("release_cmd_ready", 32'(cmd_ready), 32'h1);
        checkOutput("release_busy",      32'(busy),      32'h0);

        // Write burst at 0x3E, 4 beats, wrapping past the top of the RAM
        applyStimulus(1'b1, 1'b1, 6'h3E, 4'd3, 1'b0, 8'h00, 1'b0);
        for (int b = 0; b < 4; b++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 6'h00, 4'd0, 1'b1, wdat[b], 1'b0);
            checkOutput("wr_ready",  32'(wr_ready), 32'h1);
            checkOutput("wr_ram_we", 32'(ram_we),   32'h1);
            checkOutput("wr_addr",   32'(ram_addr), 32'(waddr[b]));
            checkOutput("wr_din",    32'(ram_din),  32'(wdat[b]));
            checkOutput("wr_busy",   32'(busy),     32'h1);
        end
        nextCycle();
        applyStimulus(1'b1, 1'b0, 6'h3E, 4'd3, 1'b0, 8'h00, 1'b1);
        checkOutput("wr_end_busy",      32'(busy),      32'h0);
        checkOutput("wr_end_cmd_ready", 32'(cmd_ready), 32'h1);
        checkOutput("wr_end_ram_we",    32'(ram_we),    32'h0);

        // Read the same burst back, one beat every two cycles
        for (int c = 0; c < 10; c++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 6'h00, 4'd0, 1'b0, 8'h00, 1'b1);
            if (c == 0) begin
                checkOutput("rd_first_addr", 32'(ram_addr), 32'h3E);
                checkOutput("rd_ram_we",     32'(ram_we),   32'h0);
            end
            if (c >= 2 && c <= 8 && (c % 2) == 0) begin
                checkOutput("rd_valid", 32'(rd_valid), 32'h1);
                checkOutput("rd_data",  32'(rd_data),  32'(wdat[(c - 2) / 2]));
                checkOutput("rd_last",  32'(rd_last),  32'((c - 2) / 2 == 3));
            end else begin
                checkOutput("rd_idle_valid", 32'(rd_valid), 32'h0);
            end
            if (c == 9) checkOutput("rd_end_busy", 32'(busy), 32'h0);
        end

        // Single-beat write of 0x5A to address 0x05, then read it back
        applyStimulus(1'b1, 1'b1, 6'h05, 4'd0, 1'b0, 8'h00, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 6'h00, 4'd0, 1'b1, 8'h5A, 1'b0);
        checkOutput("single_wr_we",   32'(ram_we),   32'h1);
        checkOutput("single_wr_addr", 32'(ram_addr), 32'h05);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 6'h05, 4'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("single_wr_end_busy", 32'(busy), 32'h0);
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 6'h00, 4'd0, 1'b0, 8'h00, 1'b1);
            if (c == 0) checkOutput("single_rd_addr", 32'(ram_addr), 32'h05);
            if (c == 1) checkOutput("single_rd_early", 32'(rd_valid), 32'h0);
            if (c == 2) begin
                checkOutput("single_rd_valid", 32'(rd_valid), 32'h1);
                checkOutput("single_rd_data",  32'(rd_data),  32'h5A);
                checkOutput("single_rd_last",  32'(rd_last),  32'h1);
            end
            if (c == 3) begin
                checkOutput("single_rd_idle_busy", 32'(busy),      32'h0);
                checkOutput("single_rd_idle_cmd",  32'(cmd_ready), 32'h1);
                checkOutput("single_rd_idle_vld",  32'(rd_valid),  32'h0);
            end
        end

        // 8-beat read from 0x10 with rd_ready low for cycles 5..9
        applyStimulus(1'b1, 1'b0, 6'h10, 4'd7, 1'b0, 8'h00, 1'b1);
        beats = 0;
        for (int c = 0; c < 22; c++) begin
            nextCycle();
            rr = !(c >= 5 && c <= 9);
            applyStimulus(1'b0, 1'b0, 6'h00, 4'd0, 1'b0, 8'h00, rr);
            expValid = (c == 2) || (c == 4) || (c >= 6 && c <= 10) ||
                       (c >= 12 && c <= 20 && (c % 2) == 0);
            checkOutput("stall_valid", 32'(rd_valid), 32'(expValid));
            if (expValid) begin
                checkOutput("stall_data", 32'(rd_data), 32'(8'h90 + 8'(beats)));
                checkOutput("stall_last", 32'(rd_last), 32'(beats == 7));
            end
            if (c == 0) checkOutput("stall_first_addr", 32'(ram_addr), 32'h10);
            if (c >= 6 && c <= 9) checkOutput("stall_addr_hold", 32'(ram_addr), 32'h13);
            if (rd_valid && rd_ready) beats++;
            if (c == 21) checkOutput("stall_end_busy", 32'(busy), 32'h0);
        end
        checkOutput("stall_beat_count", 32'(beats), 32'd8);

        // Write len 3 at 0x20 with gaps in wr_valid
        applyStimulus(1'b1, 1'b1, 6'h20, 4'd3, 1'b0, 8'h00, 1'b0);
        k = 0;
        for (int c = 0; c < 7; c++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 6'h00, 4'd0, wvPat[c], 8'hB0 + 8'(k), 1'b0);
            checkOutput("gap_ram_we", 32'(ram_we),   32'(wvPat[c]));
            checkOutput("gap_addr",   32'(ram_addr), 32'(6'h20 + 6'(k)));
            if (wvPat[c]) k++;
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 6'h00, 4'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("gap_end_busy", 32'(busy), 32'h0);
        for (int a = 0; a < 4; a++) begin
            checkOutput("gap_mem", 32'(mem[6'h20 + 6'(a)]), 32'(8'hB0 + 8'(a)));
        end
        checkOutput("gap_mem_untouched", 32'(mem[6'h24]), 32'hA4);

        // Read len 7 from 0x30, reset after the third beat is taken
        applyStimulus(1'b1, 1'b0, 6'h30, 4'd7, 1'b0, 8'h00, 1'b1);
        for (int c = 0; c < 7; c++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 6'h00, 4'd0, 1'b0, 8'h00, 1'b1);
            if (c >= 2 && (c % 2) == 0) begin
                checkOutput("pre_rst_valid", 32'(rd_valid), 32'h1);
                checkOutput("pre_rst_data",  32'(rd_data),  32'(8'hB0 + 8'((c - 2) / 2)));
            end
        end
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 6'h00, 4'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("mid_rst_valid", 32'(rd_valid),  32'h0);
        checkOutput("mid_rst_busy",  32'(busy),      32'h0);
        checkOutput("mid_rst_cmd",   32'(cmd_ready), 32'h0);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 6'h3F, 4'd1, 1'b0, 8'h00, 1'b1);
        checkOutput("post_rst_busy",  32'(busy),      32'h0);
        checkOutput("post_rst_valid", 32'(rd_valid),  32'h0);
        checkOutput("post_rst_cmd",   32'(cmd_ready), 32'h1);
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 6'h00, 4'd0, 1'b0, 8'h00, 1'b1);
            if (c == 0) checkOutput("post_rst_addr", 32'(ram_addr), 32'h3F);
            if (c == 2) begin
                checkOutput("post_rst_b0_valid", 32'(rd_valid), 32'h1);
                checkOutput("post_rst_b0_data",  32'(rd_data),  32'hA2);
                checkOutput("post_rst_b0_last",  32'(rd_last),  32'h0);
            end
            if (c == 4) begin
                checkOutput("post_rst_b1_valid", 32'(rd_valid), 32'h1);
                checkOutput("post_rst_b1_data",  32'(rd_data),  32'hA3);
                checkOutput("post_rst_b1_last",  32'(rd_last),  32'h1);
            end
            if (c == 5) checkOutput("post_rst_end_busy", 32'(busy), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
